// File: rtl/op_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and command field layout
// for the matrix-controller command front end.
package op_seq_pkg;

    localparam logic [3:0] OP_IDLE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_READ  = 4'd3;

    localparam int OPCODE_LSB  = 0;
    localparam int CHUNK_W     = 4;
    localparam int CHUNK_A_LSB = 4;
    localparam int CHUNK_B_LSB = 8;
    localparam int CHUNK_C_LSB = 12;
    localparam int CHUNK_D_LSB = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_WRITE,
        S_READ,
        S_GAP
    } state_t;

    function automatic logic opcode_unsupported(input logic [3:0] opc);
        return opc > OP_READ;
    endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Host command/data streams plus the controller-facing drive signals.
interface op_sequencer_if #(
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] operation;
    logic [DATA_W-1:0] in_data;
    logic              ctrl_enable;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  cmd_valid, cmd, wr_valid, wr_data, rd_ready, out_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, operation, in_data,
        output ctrl_enable, busy, done, err
    );

    modport master (
        output cmd_valid, cmd, wr_valid, wr_data, rd_ready, out_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, operation, in_data,
        input  ctrl_enable, busy, done, err
    );
endinterface

// File: rtl/op_sequencer_rd_stage.sv
// Single-entry read output register; adv tells the controller it may step
// because the slot is empty or being drained this cycle.
module seq_rd_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] out_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              adv
);
    assign adv = !rd_valid || rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (active && adv) begin
            rd_valid <= 1'b1;
            rd_data  <= out_data;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/op_sequencer.sv
// Command sequencer: holds each opcode on the controller for the cycles it
// needs, streams page data with backpressure, and forces an idle gap between commands.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PAGE_WORDS  = 64,
    parameter int MULT_CYCLES = 128
) (
    input logic          clk,
    input logic          reset,
    op_sequencer_if.slave bus
);
    localparam int CNT_MAX = (PAGE_WORDS > MULT_CYCLES) ? PAGE_WORDS : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PAGE_LAST = CNT_W'(PAGE_WORDS - 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] op_reg;
    logic [CNT_W-1:0]  cnt;
    logic              armed;
    logic              err_flag;
    logic              accept;
    logic              cnt_inc;
    logic              adv;

    assign accept = (state == S_IDLE) && armed && bus.cmd_valid;

    // armed keeps handshake and enable low until the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_reg   <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= state_nx;
            if (accept) begin
                op_reg   <= bus.cmd;
                err_flag <= opcode_unsupported(bus.cmd[3:0]);
                cnt      <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_inc         = 1'b0;
        bus.operation   = '0;
        bus.in_data     = '0;
        bus.ctrl_enable = armed;
        bus.wr_ready    = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        bus.busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                bus.cmd_ready = armed;
                if (accept) begin
                    case (bus.cmd[3:0])
                        OP_MULT:  state_nx = S_MULT;
                        OP_WRITE: state_nx = S_WRITE;
                        OP_READ:  state_nx = S_READ;
                        OP_IDLE:  state_nx = S_GAP;
                        default:  state_nx = S_GAP;
                    endcase
                end
            end
            S_MULT: begin
                bus.operation = op_reg;
                cnt_inc       = 1'b1;
                if (cnt == MULT_LAST) state_nx = S_GAP;
            end
            S_WRITE: begin
                bus.operation   = op_reg;
                bus.wr_ready    = 1'b1;
                bus.in_data     = bus.wr_data;
                bus.ctrl_enable = bus.wr_valid;
                if (bus.wr_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt == PAGE_LAST) state_nx = S_GAP;
                end
            end
            S_READ: begin
                bus.operation   = op_reg;
                bus.ctrl_enable = adv;
                if (adv) begin
                    cnt_inc = 1'b1;
                    if (cnt == PAGE_LAST) state_nx = S_GAP;
                end
            end
            S_GAP: begin
                bus.done = !err_flag;
                bus.err  = err_flag;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    seq_rd_stage #(.DATA_W(DATA_W)) u_rd_stage (
        .clk      (clk),
        .reset    (reset),
        .active   (state == S_READ),
        .rd_ready (bus.rd_ready),
        .out_data (bus.out_data),
        .rd_valid (bus.rd_valid),
        .rd_data  (bus.rd_data),
        .adv      (adv)
    );
endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with a small controller model and
// write/read scoreboards.
module tb_op_sequencer;
    import op_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    op_sequencer_if #(.DATA_W(32)) bus ();

    op_sequencer #(.DATA_W(32), .PAGE_WORDS(64), .MULT_CYCLES(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rd_beats = 0;
    int wr_beats = 0;
    int caps = 0;
    int out_idx = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];

    function automatic logic [31:0] ctrl_word(input int idx);
        return 32'hA500_0000 + 32'(idx) * 32'h0001_0003;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the settled pre-edge values, then advance.
    task automatic cycle();
        logic cap;
        logic [31:0] e;
        #1;
        cap = bus.ctrl_enable && (bus.operation[3:0] == OP_READ);
        if (bus.rd_valid && bus.rd_ready) begin
            if (rd_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else begin
                e = rd_q.pop_front();
                chk("rd_data", bus.rd_data, e);
            end
            rd_beats++;
        end
        if (cap) begin
            rd_q.push_back(bus.out_data);
            caps++;
        end
        if (bus.operation[3:0] == OP_READ && bus.rd_valid && !bus.rd_ready)
            chk("rd_stall_enable", 32'(bus.ctrl_enable), 32'd0);
        if (bus.ctrl_enable && bus.operation[3:0] == OP_WRITE) begin
            if (wr_q.size() == 0) chk("wr_underflow", 32'd1, 32'd0);
            else begin
                e = wr_q.pop_front();
                chk("in_data", bus.in_data, e);
            end
            wr_beats++;
        end
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        @(posedge clk);
        #1;
        if (cap) begin
            out_idx++;
            bus.out_data = ctrl_word(out_idx);
        end
    endtask

    task automatic send_cmd(input logic [31:0] c);
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_read(input logic toggle);
        int d0;
        int b0;
        int c0;
        int k;
        d0 = done_cnt; b0 = rd_beats; c0 = caps;
        send_cmd(32'h0000_0083);
        k = 0;
        while (rd_beats - b0 < 64 && k < 400) begin
            bus.rd_ready = toggle ? k[0] : 1'b1;
            cycle();
            k++;
        end
        bus.rd_ready = 1'b1;
        cycle();
        chk("rd_beats", 32'(rd_beats - b0), 32'd64);
        chk("rd_captures", 32'(caps - c0), 32'd64);
        chk("rd_done", 32'(done_cnt - d0), 32'd1);
        chk("rd_drained", 32'(bus.rd_valid), 32'd0);
        chk("rd_ready_again", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        int z;
        int d0;
        int e0;
        int word;
        bus.cmd_valid = 1'b0; bus.cmd = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        bus.rd_ready = 1'b0; bus.out_data = ctrl_word(0);
        reset = 1'b0;
        #3;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_enable", 32'(bus.ctrl_enable), 32'd0);
        chk("rst_operation", bus.operation, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cycle();
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_enable", 32'(bus.ctrl_enable), 32'd1);

        // MULT hold length, gap and done
        d0 = done_cnt;
        send_cmd(32'h0000_1801);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!(bus.operation == 32'h0000_1801 && bus.ctrl_enable)) break;
            n++;
            cycle();
        end
        chk("mult_len", 32'(n), 32'd128);
        chk("mult_gap_op", bus.operation, 32'd0);
        chk("mult_gap_done", 32'(bus.done), 32'd1);
        chk("mult_gap_ready", 32'(bus.cmd_ready), 32'd0);
        cycle();
        chk("mult_ready_again", 32'(bus.cmd_ready), 32'd1);
        chk("mult_done_count", 32'(done_cnt - d0), 32'd1);

        // WRITE with every third beat stalled
        d0 = done_cnt; wr_beats = 0;
        send_cmd(32'h0000_0082);
        #1 chk("wr_ready", 32'(bus.wr_ready), 32'd1);
        word = 0;
        for (int k = 0; k < 200 && word < 64; k++) begin
            bus.wr_valid = (k % 3) != 2;
            bus.wr_data = bus.wr_valid ? 32'(word) : (32'hDEAD_0000 | 32'(k));
            if (bus.wr_valid) begin
                wr_q.push_back(32'(word));
                word++;
            end
            cycle();
        end
        bus.wr_valid = 1'b0;
        #1;
        chk("wr_beats", 32'(wr_beats), 32'd64);
        chk("wr_gap_done", 32'(bus.done), 32'd1);
        chk("wr_in_data_gap", bus.in_data, 32'd0);
        cycle();
        chk("wr_done_count", 32'(done_cnt - d0), 32'd1);
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);

        // READ with rd_ready toggling
        run_read(1'b1);

        // Back-to-back MULT with cmd_valid held
        bus.cmd = 32'h0000_1801;
        bus.cmd_valid = 1'b1;
        cycle();
        n = 0; z = 0; d0 = done_cnt;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.operation != 32'h0000_1801) break;
            n++;
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.operation != 32'd0) break;
            z++;
            if (bus.cmd_ready) begin
                cycle();
                bus.cmd_valid = 1'b0;
            end else cycle();
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_first_len", 32'(n), 32'd128);
        chk("b2b_zero_cycles", 32'(z), 32'd2);
        chk("b2b_gap_done", 32'(done_cnt - d0), 32'd1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.operation != 32'h0000_1801) break;
            n++;
            cycle();
        end
        chk("b2b_second_len", 32'(n), 32'd128);
        cycle();
        chk("b2b_idle", 32'(bus.cmd_ready), 32'd1);

        // Unsupported opcode
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(32'h0000_0007);
        #1;
        chk("err_pulse", 32'(bus.err), 32'd1);
        chk("err_no_done", 32'(bus.done), 32'd0);
        chk("err_operation", bus.operation, 32'd0);
        cycle();
        chk("err_idle", 32'(bus.cmd_ready), 32'd1);
        chk("err_count", 32'(err_cnt - e0), 32'd1);
        chk("err_done_count", 32'(done_cnt - d0), 32'd0);

        // Reset during write beat 10, then a full read
        d0 = done_cnt; wr_beats = 0;
        send_cmd(32'h0000_0082);
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data = 32'h100 + 32'(i);
            wr_q.push_back(32'h100 + 32'(i));
            cycle();
        end
        chk("rst_wr_beats", 32'(wr_beats), 32'd10);
        bus.wr_data = 32'h10A;
        reset = 1'b0;
        #1;
        chk("midrst_operation", bus.operation, 32'd0);
        chk("midrst_enable", 32'(bus.ctrl_enable), 32'd0);
        chk("midrst_in_data", bus.in_data, 32'd0);
        chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("midrst_rd_data", bus.rd_data, 32'd0);
        bus.wr_valid = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        run_read(1'b0);
        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
